// File: rtl/tc_interval_timer.sv
// Purpose: interval timer; ticks COUNT cycles after an accepted start, once (one-shot) or every COUNT cycles (periodic).
// Latency: all outputs registered; first tick_o exactly COUNT cycles after the edge that accepted start_i.
// Backpressure: a tick raises evt_valid_o until evt_ready_i takes it; a tick while one is still pending sets sticky overrun_o.
// Ports: clk_i/rst_n_i clock and async active-low reset; start_i, abort_i, periodic_i control;
//        evt_ready_i/clear_i event handshake and clear; busy_o, tick_o, evt_valid_o, overrun_o, tick_cnt_o status.
module tc_interval_timer #(
   parameter int COUNT = 100,
   parameter int EVT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             periodic_i,
   input  logic             evt_ready_i,
   input  logic             clear_i,
   output logic             busy_o,
   output logic             tick_o,
   output logic             evt_valid_o,
   output logic             overrun_o,
   output logic [EVT_W-1:0] tick_cnt_o
);

   if (COUNT < 1 || COUNT > (1 << 20)) begin : g_bad_count
      $error("tc_interval_timer: COUNT must lie in 1..2^20");
   end

   // The counter starts at LOAD and runs up; COUNT increments later it
   // reaches 2^CW, i.e. the MSB sets. No comparison against COUNT is needed.
   localparam int           CW   = $clog2(COUNT);
   localparam int           W    = CW + 1;
   localparam logic [W-1:0] LOAD = W'((1 << CW) - COUNT);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     cnt_q, cnt_d, cnt_inc;
   logic             mode_q, mode_d;
   logic             term;
   logic             tick_d;
   logic             evt_d;
   logic             ovr_d;
   logic [EVT_W-1:0] tcnt_d;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         cnt_q       <= LOAD;
         mode_q      <= 1'b0;
         tick_o      <= 1'b0;
         evt_valid_o <= 1'b0;
         overrun_o   <= 1'b0;
         tick_cnt_o  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         tick_o      <= tick_d;
         evt_valid_o <= evt_d;
         overrun_o   <= ovr_d;
         tick_cnt_o  <= tcnt_d;
      end
   end

   // busy_o is the state flop itself, so it stays a registered output.
   assign busy_o = (state_q == RUN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      tick_d  = 1'b0;
      cnt_inc = cnt_q + W'(1);
      // Terminal edge: the increment is about to set the MSB for the first time.
      term    = (state_q == RUN) && !cnt_q[W-1] && cnt_inc[W-1];

      if (abort_i) begin
         state_d = IDLE;
         cnt_d   = LOAD;
      end else if (start_i) begin
         // Start or restart; a restart swallows a coincident terminal edge.
         state_d = RUN;
         cnt_d   = LOAD;
         mode_d  = periodic_i;
      end else if (state_q == RUN) begin
         if (cnt_q[W-1]) begin
            // One-shot only: the counter holds its MSB during the tick
            // cycle, and the timer drops out of RUN on the following edge.
            state_d = IDLE;
            cnt_d   = LOAD;
         end else if (term) begin
            tick_d = 1'b1;
            // Periodic reloads on the terminal edge so ticks have no gap.
            cnt_d  = mode_q ? LOAD : cnt_inc;
         end else begin
            cnt_d = cnt_inc;
         end
      end

      // A new tick keeps the event pending even when the old one is taken.
      evt_d = evt_valid_o;
      if (tick_d) begin
         evt_d = 1'b1;
      end else if (evt_valid_o && evt_ready_i) begin
         evt_d = 1'b0;
      end

      // Setting beats clearing.
      ovr_d = overrun_o;
      if (clear_i) begin
         ovr_d = 1'b0;
      end
      if (tick_d && evt_valid_o && !evt_ready_i) begin
         ovr_d = 1'b1;
      end

      tcnt_d = tick_cnt_o;
      if (clear_i) begin
         tcnt_d = tick_d ? EVT_W'(1) : '0;
      end else if (tick_d) begin
         tcnt_d = tick_cnt_o + EVT_W'(1);
      end
   end

endmodule

// File: tb/tb_tc_interval_timer.sv
// Purpose: scoreboard bench; five timer instances (COUNT 5, 8, 6, 4, 1) get directed then random stimulus.
// Latency: a reference model pushes the expected outputs of every edge; a monitor pops and compares 1 time unit later.
// Backpressure: evt_ready_i is driven randomly so pending events, overruns and clears are all exercised.
module tb_tc_interval_timer;

   localparam int NI = 5;

   typedef struct packed {
      logic       busy;
      logic       tick;
      logic       evt;
      logic       ovr;
      logic [7:0] cnt;
   } obs_t;

   function automatic int cnt_of(input int i);
      case (i)
         0:       return 5;
         1:       return 8;
         2:       return 6;
         3:       return 4;
         default: return 1;
      endcase
   endfunction

   // The COUNT=1 instance ticks every cycle, so a narrow counter shows wrapping.
   function automatic int ew_of(input int i);
      return (i == 4) ? 4 : 8;
   endfunction

   logic clk;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_done = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
      end
   endtask

   for (genvar gi = 0; gi < NI; gi++) begin : g_t
      localparam int C  = cnt_of(gi);
      localparam int EW = ew_of(gi);

      logic          rst_n, start, abort, per, rdy, clr;
      logic          busy, tick, evt, ovr;
      logic [EW-1:0] tcnt;
      obs_t          q[$];
      bit            dir_go   = 1'b0;
      bit            dir_done = 1'b0;

      tc_interval_timer #(.COUNT(C), .EVT_W(EW)) u_dut (
         .clk_i      (clk),
         .rst_n_i    (rst_n),
         .start_i    (start),
         .abort_i    (abort),
         .periodic_i (per),
         .evt_ready_i(rdy),
         .clear_i    (clr),
         .busy_o     (busy),
         .tick_o     (tick),
         .evt_valid_o(evt),
         .overrun_o  (ovr),
         .tick_cnt_o (tcnt)
      );

      // Inputs change right after a falling edge; one call covers one rising edge.
      task automatic cyc(input bit s, input bit a, input bit p, input bit r, input bit c, input bit rn);
         start = s;
         abort = a;
         per   = p;
         rdy   = r;
         clr   = c;
         rst_n = rn;
         @(negedge clk);
      endtask

      task automatic idle(input int n, input bit r);
         for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, r, 1'b0, 1'b1);
      endtask

      // Reference model: timing from the cycle distance since the accepted start.
      initial begin : model
         int   e_idx, t0, d, cnt_m;
         bit   run, perm, ev, ov, tk, nov, nev;
         obs_t o;
         e_idx = 0; t0 = 0; cnt_m = 0;
         run = 0; perm = 0; ev = 0; ov = 0;
         forever begin
            @(posedge clk);
            tk = 0;
            if (!rst_n) begin
               run = 0; ev = 0; ov = 0; cnt_m = 0;
            end else begin
               if (abort) begin
                  run = 0;
               end else if (start) begin
                  run  = 1;
                  t0   = e_idx;
                  perm = per;
               end else if (run) begin
                  d = e_idx - t0;
                  if (perm) tk = (d % C == 0);
                  else if (d == C) tk = 1;
                  else if (d > C) run = 0;
               end
               nov = ov;
               if (clr) nov = 0;
               if (tk && ev && !rdy) nov = 1;
               nev = tk ? 1'b1 : ((ev && rdy) ? 1'b0 : ev);
               if (clr) cnt_m = tk ? 1 : 0;
               else cnt_m = (cnt_m + (tk ? 1 : 0)) % (1 << EW);
               ov = nov;
               ev = nev;
            end
            o.busy = run;
            o.tick = tk;
            o.evt  = ev;
            o.ovr  = ov;
            o.cnt  = 8'(cnt_m);
            q.push_back(o);
            e_idx++;
         end
      end

      initial begin : monitor
         obs_t g, e;
         forever begin
            @(posedge clk);
            #1;
            g = {busy, tick, evt, ovr, 8'(tcnt)};
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL c%0d_queue: got empty scoreboard expected an entry", C);
            end else begin
               e = q.pop_front();
               chk($sformatf("c%0d_cycle", C), int'(g), int'(e));
            end
         end
      end

      initial begin : stim
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         chk($sformatf("c%0d_rst_state", C), int'({busy, tick, evt, ovr, tcnt}), 0);
         dir_go = 1'b1;
         wait (dir_done);
         for (int k = 0; k < 400; k++) begin
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                $urandom_range(0, 29) == 0, $urandom_range(0, 149) != 0);
         end
         idle(2, 1'b1);
         n_done++;
      end

      if (gi == 0) begin : g_d0
         initial begin
            wait (dir_go);
            // One-shot, start at edge 0.
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            idle(4, 1'b1);
            chk("c5_os_notick_e4", tick, 0);
            idle(1, 1'b1);
            chk("c5_os_tick_e5", tick, 1);
            chk("c5_os_busy_e5", busy, 1);
            idle(1, 1'b1);
            chk("c5_os_busy_e6", busy, 0);
            chk("c5_os_tick_e6", tick, 0);
            chk("c5_os_cnt_e6", tcnt, 1);
            // Periodic with the consumer stalled.
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            idle(4, 1'b0);
            chk("c5_pe_evt_e4", evt, 0);
            idle(1, 1'b0);
            chk("c5_pe_evt_e5", evt, 1);
            chk("c5_pe_ovr_e5", ovr, 0);
            idle(5, 1'b0);
            chk("c5_pe_ovr_e10", ovr, 1);
            chk("c5_pe_cnt_e10", tcnt, 2);
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            chk("c5_clr_ovr", ovr, 0);
            chk("c5_clr_cnt", tcnt, 0);
            chk("c5_abort_busy", busy, 0);
            dir_done = 1'b1;
         end
      end else if (gi == 1) begin : g_d1
         initial begin
            wait (dir_go);
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            idle(7, 1'b1);
            chk("c8_notick_e7", tick, 0);
            idle(1, 1'b1);
            chk("c8_tick_e8", tick, 1);
            idle(1, 1'b1);
            chk("c8_notick_e9", tick, 0);
            idle(7, 1'b1);
            chk("c8_tick_e16", tick, 1);
            idle(8, 1'b1);
            chk("c8_tick_e24", tick, 1);
            chk("c8_cnt_e24", tcnt, 3);
            chk("c8_ovr_e24", ovr, 0);
            chk("c8_busy_e24", busy, 1);
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            chk("c8_abort_busy", busy, 0);
            dir_done = 1'b1;
         end
      end else if (gi == 2) begin : g_d2
         initial begin
            wait (dir_go);
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            idle(3, 1'b1);
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            idle(2, 1'b1);
            chk("c6_rs_notick_e6", tick, 0);
            chk("c6_rs_busy_e6", busy, 1);
            idle(3, 1'b1);
            chk("c6_rs_notick_e9", tick, 0);
            idle(1, 1'b1);
            chk("c6_rs_tick_e10", tick, 1);
            chk("c6_rs_cnt_e10", tcnt, 1);
            idle(2, 1'b1);
            chk("c6_os_done", busy, 0);
            dir_done = 1'b1;
         end
      end else if (gi == 3) begin : g_d3
         initial begin
            wait (dir_go);
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            idle(3, 1'b1);
            cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            chk("c4_ab_notick", tick, 0);
            chk("c4_ab_busy", busy, 0);
            chk("c4_ab_cnt", tcnt, 0);
            idle(4, 1'b1);
            chk("c4_ab_idle", busy, 0);
            chk("c4_ab_cnt_later", tcnt, 0);
            // Restart exactly on the terminal edge.
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            idle(3, 1'b1);
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            chk("c4_rs_notick", tick, 0);
            chk("c4_rs_busy", busy, 1);
            idle(4, 1'b1);
            chk("c4_rs_tick", tick, 1);
            chk("c4_rs_cnt", tcnt, 1);
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            dir_done = 1'b1;
         end
      end else begin : g_d4
         initial begin
            wait (dir_go);
            cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            idle(1, 1'b1);
            chk("c1_tick_e1", tick, 1);
            idle(1, 1'b1);
            chk("c1_tick_e2", tick, 1);
            chk("c1_cnt_e2", tcnt, 2);
            idle(14, 1'b1);
            chk("c1_tick_e16", tick, 1);
            chk("c1_cnt_wrap", tcnt, 0);
            // Reset in the middle of a cycle must clear outputs before the next edge.
            #2 rst_n = 1'b0;
            #1 chk("c1_arst", int'({busy, tick, evt, ovr, tcnt}), 0);
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            idle(1, 1'b1);
            chk("c1_os_tick", tick, 1);
            chk("c1_os_busy", busy, 1);
            idle(1, 1'b1);
            chk("c1_os_busy_off", busy, 0);
            chk("c1_os_notick", tick, 0);
            dir_done = 1'b1;
         end
      end
   end

   initial begin
      for (int t = 0; t < 20000 && n_done < NI; t++) @(posedge clk);
      if (n_done < NI) begin
         n_chk++;
         n_fail++;
         $display("FAIL timeout: got %0d instances done expected %0d", n_done, NI);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tc_interval_timer.md
TC_INTERVAL_TIMER -- requirements
Module: tc_interval_timer

Interface
REQ-001 SHALL have parameter COUNT, 100, cycles between start and terminal tick (legal range 1..2^20; values outside this range are an elaboration error).
REQ-002 SHALL have parameter EVT_W, 8, width of the tick counter output.
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start_i  input  1  start/restart request, sampled each cycle.
REQ-006 SHALL have port abort_i  input  1  stop request; returns the block to IDLE.
REQ-007 SHALL have port periodic_i  input  1  mode select, sampled only on an accepted start (1 = periodic, 0 = one-shot).
REQ-008 SHALL have port evt_ready_i  input  1  consumer accepts the pending event.
REQ-009 SHALL have port clear_i  input  1  clears overrun_o and tick_cnt_o.
REQ-010 SHALL have port busy_o  output  1  high in the RUN state.
REQ-011 SHALL have port tick_o  output  1  one-cycle pulse at terminal count.
REQ-012 SHALL have port evt_valid_o  output  1  pending-event flag, held until accepted.
REQ-013 SHALL have port overrun_o  output  1  sticky flag: a tick occurred while an event was still pending.
REQ-014 SHALL have port tick_cnt_o  output  EVT_W  ticks since the last clear, wrapping.

Function
REQ-015 SHALL use an internal counter of width W = clog2(COUNT)+1, load value L = 2^clog2(COUNT) - COUNT, and terminal condition counter MSB = 1.
- Arithmetic and terminal detection SHALL NOT use a comparator against COUNT.
REQ-016 SHALL implement exactly two states, IDLE and RUN.
- IDLE->RUN: start_i=1 and abort_i=0; counter loaded with L; mode latched from periodic_i.
REQ-017 SHALL behave as follows in RUN: counter increments by 1 each cycle; tick_o=1 in the cycle the MSB is first seen set, i.e. exactly COUNT cycles after the edge that accepted start.
REQ-018 SHALL, in periodic mode, reload the counter with L on the terminal cycle so that ticks repeat every COUNT cycles with no gap cycle; busy_o SHALL stay 1.
REQ-019 SHALL, in one-shot mode, return to IDLE on the terminal cycle; busy_o=0 from the following cycle.
REQ-020 SHALL treat start_i=1 in RUN (abort_i=0) as a restart.
- Counter reloaded with L and mode re-latched.
- No tick is produced in the restart cycle, even if that cycle is terminal.
REQ-021 SHALL treat abort_i=1 (any state) as: go to IDLE next cycle with no tick.
- abort_i wins over start_i and over a coincident terminal count.
REQ-022 SHALL handle COUNT=1 as follows: W=1, L=0, tick every cycle in periodic mode.
REQ-023 SHALL set evt_valid_o on each tick and clear it on the cycle after evt_valid_o=1 and evt_ready_i=1.
- Tick coincident with acceptance: evt_valid_o stays 1 (new event); overrun not set.
REQ-024 SHALL set overrun_o when a tick occurs while evt_valid_o=1 and evt_ready_i=0.
- overrun_o clears only on clear_i or reset.
- clear_i coincident with an overrun-causing tick: overrun_o=1 (set wins).
REQ-025 SHALL increment tick_cnt_o modulo 2^EVT_W on every tick.
- clear_i zeroes it; clear_i coincident with a tick: result is 1.
REQ-026 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-027 SHALL, while rst_n_i=0, force IDLE and counter=L, and force all outputs to 0 (busy_o, tick_o, evt_valid_o, overrun_o, tick_cnt_o=0), asynchronously.
REQ-028 SHALL, on release of rst_n_i, ignore inputs until the first rising edge; reset mid-RUN discards the pending event and all state.

Verification
REQ-029 SHALL cover: COUNT=5, one-shot, start at edge 0 -> tick_o=1 only at edge 5; busy_o falls at edge 6; tick_cnt_o=1.
REQ-030 SHALL cover: COUNT=8, periodic, evt_ready_i=1 -> ticks at edges 8,16,24; overrun_o stays 0; tick_cnt_o=3 after edge 24.
REQ-031 SHALL cover: COUNT=5, periodic, evt_ready_i=0 -> evt_valid_o=1 from edge 5; overrun_o=1 at edge 10; clear_i -> overrun_o=0, tick_cnt_o=0.
REQ-032 SHALL cover: COUNT=6, restart at edge 4 -> no tick at edge 6; first tick at edge 10.
REQ-033 SHALL cover: COUNT=4, abort_i and start_i both high at the terminal edge -> no tick; IDLE; busy_o=0.
REQ-034 SHALL cover: COUNT=1, periodic -> tick_o=1 every cycle from edge 1; rst_n_i low mid-run -> all outputs 0 immediately, before the next clock edge.
